// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//
// Purpose:
//   Decode-stage micro-sequencer for the load-multiple (LM) and
//   store-multiple (SM) instructions. A single instruction carries an 8-bit
//   register list. This block expands that list into one single-register
//   memory micro-op per cycle, presented to ID/EX. It freezes PC and IF/ID
//   while it is expanding.
//
//   Registers are issued in ascending order (R0 first, R7 last). Addresses
//   are consecutive from the base address, so the k-th issued uop uses
//   base_addr + k no matter which list bits are clear.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   instr_valid  ID holds a valid instruction
//   opcode       ID instruction opcode
//   reg_list     ID imm8; bit i set means register Ri is transferred
//   base_addr    value of RA read in ID (start address)
//   stall_in     downstream hold of ID/EX; freezes the current uop
//   flush        squash of ID (branch / R7 redirect); aborts a sequence
//   uop_valid    micro-op presented to ID/EX this cycle
//   uop_LM       uop is a load (register write)
//   uop_SM       uop is a store (no register write)
//   uop_rd       register for this uop (load dest / store source)
//   uop_addr     memory address for this uop
//   uop_last     uop is the final one of the instruction
//   hold_fetch   freeze PC and IF/ID
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
  parameter int          ADDR_W = 16,
  parameter logic [3:0]  LM_OP  = 4'b0110,
  parameter logic [3:0]  SM_OP  = 4'b0111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [7:0]        reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stall_in,
  input  logic              flush,
  output logic              uop_valid,
  output logic              uop_LM,
  output logic              uop_SM,
  output logic [2:0]        uop_rd,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              hold_fetch
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_lm_q, is_lm_d;

  logic              accept;
  logic              issuing;
  logic              last_uop;
  logic [2:0]        low_idx;

  // Lowest set bit of the remaining mask selects the register to issue.
  // The loop runs from high to low so the lowest set bit is written last
  // and wins.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  // The last uop is the one where exactly one bit remains. Clearing the
  // lowest set bit of a one-hot mask leaves zero.
  assign last_uop = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);

  assign issuing = (state_q == ISSUE);

  // An empty register list never starts a sequence. Such an instruction
  // flows through as a NOP without holding fetch.
  assign accept = (state_q == IDLE) && instr_valid &&
                  ((opcode == LM_OP) || (opcode == SM_OP)) &&
                  !stall_in && !flush && (reg_list != 8'd0);

  // Next-state logic. flush has priority over stall_in while issuing.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    is_lm_d = is_lm_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          mask_d  = reg_list;
          addr_d  = base_addr;
          is_lm_d = (opcode == LM_OP);
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
          mask_d  = 8'd0;
        end else if (!stall_in) begin
          mask_d = mask_q & (mask_q - 8'd1);
          addr_d = addr_q + ADDR_W'(1);
          if (last_uop) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      addr_q  <= '0;
      is_lm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      is_lm_q <= is_lm_d;
    end
  end

  // Outputs come only from registers. They are gated by ISSUE so that idle
  // cycles present all zeros, even though addr_q keeps its last value.
  assign uop_valid  = issuing;
  assign uop_LM     = issuing && is_lm_q;
  assign uop_SM     = issuing && !is_lm_q;
  assign uop_rd     = issuing ? low_idx : 3'd0;
  assign uop_addr   = issuing ? addr_q : '0;
  assign uop_last   = issuing && last_uop;
  assign hold_fetch = issuing;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
//
// Self-checking bench for lm_sm_sequencer. A behavioural reference model
// holds a queue of pending uops. When an instruction is accepted, the model
// builds the whole queue from the register list: ascending registers, with
// address base+k for the k-th entry. Each cycle the model then pops, holds
// or clears that queue.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

   localparam logic [3:0] LmOp  = 4'b0110;
   localparam logic [3:0] SmOp  = 4'b0111;
   localparam logic [3:0] AddOp = 4'b0000;

   logic        clk;
   logic        reset;
   logic        instrValid;
   logic [3:0]  opcode;
   logic [7:0]  regList;
   logic [15:0] baseAddr;
   logic        stallIn;
   logic        flush;
   logic        uopValid;
   logic        uopLm;
   logic        uopSm;
   logic [2:0]  uopRd;
   logic [15:0] uopAddr;
   logic        uopLast;
   logic        holdFetch;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] addr;
   } uop_t;

   uop_t modelQ[$];
   logic modelIsLm;
   int   checkCount;
   int   errorCount;

   lm_sm_sequencer #(.ADDR_W(16), .LM_OP(LmOp), .SM_OP(SmOp)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instrValid),
      .opcode      (opcode),
      .reg_list    (regList),
      .base_addr   (baseAddr),
      .stall_in    (stallIn),
      .flush       (flush),
      .uop_valid   (uopValid),
      .uop_LM      (uopLm),
      .uop_SM      (uopSm),
      .uop_rd      (uopRd),
      .uop_addr    (uopAddr),
      .uop_last    (uopLast),
      .hold_fetch  (holdFetch)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: it counts the check and reports any difference.
   task automatic checkField(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advances the reference model by one clock edge, using the inputs that
   // were present at that edge.
   task automatic modelStep();
      if (reset) begin
         modelQ.delete();
      end else if (modelQ.size() != 0) begin
         if (flush) begin
            modelQ.delete();
         end else if (!stallIn) begin
            void'(modelQ.pop_front());
         end
      end else if (instrValid && (opcode == LmOp || opcode == SmOp) &&
                   !stallIn && !flush && regList != 8'd0) begin
         int k;
         uop_t u;
         k = 0;
         modelIsLm = (opcode == LmOp);
         for (int r = 0; r < 8; r++) begin
            if (regList[r]) begin
               u.rd   = 3'(r);
               u.addr = baseAddr + 16'(k);
               modelQ.push_back(u);
               k++;
            end
         end
      end
   endtask

   // Compares every output with what the model says should be presented now.
   task automatic checkOutput(input string tag);
      logic        expValid;
      logic [2:0]  expRd;
      logic [15:0] expAddr;
      expValid = (modelQ.size() != 0);
      expRd    = expValid ? modelQ[0].rd : 3'd0;
      expAddr  = expValid ? modelQ[0].addr : 16'd0;
      checkField({tag, ".valid"}, 16'(uopValid), 16'(expValid));
      checkField({tag, ".lm"},    16'(uopLm),    16'(expValid && modelIsLm));
      checkField({tag, ".sm"},    16'(uopSm),    16'(expValid && !modelIsLm));
      checkField({tag, ".rd"},    16'(uopRd),    16'(expRd));
      checkField({tag, ".addr"},  uopAddr,       expAddr);
      checkField({tag, ".last"},  16'(uopLast),  16'(modelQ.size() == 1));
      checkField({tag, ".hold"},  16'(holdFetch), 16'(expValid));
   endtask

   // Drives one cycle of inputs on the falling edge. It then steps the model
   // on the rising edge and checks the outputs shortly after that edge.
   task automatic applyStimulus(input string tag, input logic iv, input logic [3:0] op,
                                input logic [7:0] rl, input logic [15:0] base,
                                input logic st, input logic fl, input logic rst);
      @(negedge clk);
      instrValid = iv;
      opcode     = op;
      regList    = rl;
      baseAddr   = base;
      stallIn    = st;
      flush      = fl;
      reset      = rst;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      modelIsLm  = 1'b0;
      instrValid = 1'b0;
      opcode     = AddOp;
      regList    = 8'd0;
      baseAddr   = 16'd0;
      stallIn    = 1'b0;
      flush      = 1'b0;
      reset      = 1'b1;

      $display("[TB] reset");
      applyStimulus("rst0", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
      applyStimulus("rst1", 1'b1, LmOp,  8'hFF, 16'h1234, 1'b0, 1'b0, 1'b1);
      applyStimulus("idle", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] LM list 0x05 base 0x0040");
      applyStimulus("lm05a", 1'b1, LmOp, 8'h05, 16'h0040, 1'b0, 1'b0, 1'b0);
      checkField("lm05.first.addr", uopAddr, 16'h0040);
      applyStimulus("lm05b", 1'b1, LmOp, 8'h05, 16'h0040, 1'b0, 1'b0, 1'b0);
      checkField("lm05.second.rd", 16'(uopRd), 16'd2);
      checkField("lm05.second.addr", uopAddr, 16'h0041);
      checkField("lm05.second.last", 16'(uopLast), 16'd1);
      applyStimulus("lm05c", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] SM list 0xFF base 0xFFFE with 2-cycle stall");
      applyStimulus("smff0", 1'b1, SmOp, 8'hFF, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      for (int s = 1; s <= 10; s++) begin
         applyStimulus($sformatf("smff%0d", s), 1'b0, AddOp, 8'h00, 16'h0000,
                       (s == 3 || s == 4), 1'b0, 1'b0);
         if (s == 9) begin
            checkField("smff.lastaddr", uopAddr, 16'h0005);
            checkField("smff.lastrd", 16'(uopRd), 16'd7);
         end
      end
      checkField("smff.done", 16'(holdFetch), 16'd0);

      $display("[TB] LM list 0x80 and empty list");
      applyStimulus("lm80a", 1'b1, LmOp, 8'h80, 16'h0100, 1'b0, 1'b0, 1'b0);
      checkField("lm80.rd", 16'(uopRd), 16'd7);
      checkField("lm80.last", 16'(uopLast), 16'd1);
      applyStimulus("lm80b", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus("lm00", 1'b1, LmOp, 8'h00, 16'h0200, 1'b0, 1'b0, 1'b0);
      checkField("lm00.hold", 16'(holdFetch), 16'd0);
      applyStimulus("lm00b", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] LM list 0x0F flushed on 2nd uop");
      applyStimulus("lm0fa", 1'b1, LmOp, 8'h0F, 16'h0300, 1'b0, 1'b0, 1'b0);
      applyStimulus("lm0fb", 1'b1, LmOp, 8'h0F, 16'h0300, 1'b0, 1'b0, 1'b0);
      applyStimulus("lm0fc", 1'b0, AddOp, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0);
      checkField("lm0f.flushvalid", 16'(uopValid), 16'd0);
      applyStimulus("lm0fd", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset during SM list 0x3C, then ADD");
      applyStimulus("sm3ca", 1'b1, SmOp, 8'h3C, 16'h0400, 1'b0, 1'b0, 1'b0);
      applyStimulus("sm3cb", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus("sm3cr", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
      applyStimulus("add0", 1'b1, AddOp, 8'hFF, 16'h0500, 1'b0, 1'b0, 1'b0);
      applyStimulus("add1", 1'b1, AddOp, 8'hFF, 16'h0500, 1'b0, 1'b0, 1'b0);

      $display("[TB] accept attempted under stall");
      applyStimulus("stacc0", 1'b1, SmOp, 8'h12, 16'h0600, 1'b1, 1'b0, 1'b0);
      applyStimulus("stacc1", 1'b1, SmOp, 8'h12, 16'h0600, 1'b1, 1'b0, 1'b0);
      applyStimulus("stacc2", 1'b1, SmOp, 8'h12, 16'h0600, 1'b0, 1'b0, 1'b0);
      checkField("stacc.first.rd", 16'(uopRd), 16'd1);
      applyStimulus("stacc3", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
      applyStimulus("stacc4", 1'b0, AddOp, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 500; n++) begin
         logic [3:0] op;
         logic [7:0] rl;
         case ($urandom_range(0, 3))
            0:       op = LmOp;
            1:       op = SmOp;
            2:       op = 4'($urandom);
            default: op = LmOp;
         endcase
         rl = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         applyStimulus("rand", 1'($urandom_range(0, 3) != 0), op, rl, 16'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 49) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
